// File: rtl/fetch_pc_unit.sv
// Fetch stage for the RV32I core: owns the PC, requests instruction words,
// holds the fetched word for decode until execute consumes it, then resolves the next PC.
module fetch_pc_unit #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            exec_done,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_pc;
  logic [XLEN-1:0] next_pc;
  logic            next_aligned;
  logic            pc_load;
  logic            instr_load;

  // Next-PC resolution; all sums wrap modulo 2^XLEN.
  always_comb begin
    seq_pc     = pc_q + XLEN'(4);
    rel_pc     = pc_q + imm;
    jalr_pc    = rs1_data + imm;
    jalr_pc[0] = 1'b0;
    if (jalr)
      next_pc = jalr_pc;
    else if (jump)
      next_pc = rel_pc;
    else if (branch && branch_taken)
      next_pc = rel_pc;
    else
      next_pc = seq_pc;
    next_aligned = (next_pc[1:0] == 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_load = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          if (next_aligned) begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_TRAP;
          end
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      if (pc_load)
        pc_q <= next_pc;
      if (instr_load)
        instr_q <= imem_rdata;
    end
  end

  // Strobes decode directly from the registered state, so they share its async reset.
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_HOLD);
    misaligned  = (state_q == S_TRAP);
    imem_addr   = pc_q;
    pc          = pc_q;
    pc_plus4    = seq_pc;
    instr       = instr_q;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: sequential fetch, branches,
// JAL/JALR, wrap-around, dropped responses, misalignment trap, mid-flight reset and stalls.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        branch;
  logic        jump;
  logic        jalr;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .exec_done(exec_done), .branch(branch), .jump(jump), .jalr(jalr),
    .branch_taken(branch_taken), .imm(imm), .rs1_data(rs1_data),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    exec_done = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    branch_taken = 1'b0; imm = '0; rs1_data = '0;
  endtask

  // Drives one instruction from FETCH through HOLD to its exec_done edge; returns observations.
  task automatic run_instr(input logic [31:0] word, input int rv_delay, input int hold_delay,
                           input logic br, input logic jp, input logic jr, input logic tk,
                           input logic [31:0] im, input logic [31:0] rs1,
                           output logic [31:0] faddr, output logic [31:0] hinstr,
                           output logic [31:0] hpc, output logic [31:0] hp4,
                           output int reqs, output int vcyc, output int ncyc, output bit stable);
    faddr = imem_addr; reqs = int'(imem_req); vcyc = 0; ncyc = 0; stable = 1'b1;
    step(); ncyc++; reqs += int'(imem_req); vcyc += int'(instr_valid);
    repeat (rv_delay) begin
      step(); ncyc++; reqs += int'(imem_req); vcyc += int'(instr_valid);
    end
    imem_rvalid = 1'b1; imem_rdata = word;
    step(); ncyc++;
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    hinstr = instr; hpc = pc; hp4 = pc_plus4;
    reqs += int'(imem_req); vcyc += int'(instr_valid);
    repeat (hold_delay) begin
      step(); ncyc++; reqs += int'(imem_req); vcyc += int'(instr_valid);
      if (instr !== hinstr || pc !== hpc) stable = 1'b0;
    end
    branch = br; jump = jp; jalr = jr; branch_taken = tk; imm = im; rs1_data = rs1;
    exec_done = 1'b1;
    step(); ncyc++;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step(); step();
    checks++;
    if (pc !== 32'h0 || instr !== 32'h13 || instr_valid !== 1'b0 || imem_req !== 1'b0 || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_state pc=%h instr=%h valid=%b req=%b mis=%b required pc=0 instr=13 valid=0 req=0 mis=0",
               pc, instr, instr_valid, imem_req, misaligned);
    end
    reset = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL boot_fetch req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    for (int i = 0; i < 3; i++) begin
      run_instr(32'h0010_0093 + 32'(i), 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, fa, hi, hp, h4, rq, vc, nc, st);
      checks++;
      if (fa !== 32'(i * 4)) begin
        failures++; $display("FAIL seq_addr%0d got=%h required=%h", i, fa, 32'(i * 4));
      end
      checks++;
      if (vc !== 1 || nc !== 4 || rq !== 1) begin
        failures++; $display("FAIL seq_duty%0d valid=%0d cycles=%0d reqs=%0d required 1/4/1", i, vc, nc, rq);
      end
      checks++;
      if (hi !== 32'h0010_0093 + 32'(i) || hp !== fa) begin
        failures++; $display("FAIL seq_hold%0d instr=%h pc=%h required instr=%h pc=%h", i, hi, hp, 32'h0010_0093 + 32'(i), fa);
      end
    end
    checks++;
    if (imem_addr !== 32'h0C || imem_req !== 1'b1) begin
      failures++; $display("FAIL seq_next addr=%h req=%b required 0000000c/1", imem_addr, imem_req);
    end
  endtask

  task automatic test_branch();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    run_instr(32'h0040_006F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4, '0, fa, hi, hp, h4, rq, vc, nc, st);
    run_instr(32'hFE00_0CE3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (fa !== 32'h10 || imem_addr !== 32'h08) begin
      failures++; $display("FAIL branch_taken from=%h to=%h required 00000010 -> 00000008", fa, imem_addr);
    end
    run_instr(32'h0080_006F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, '0, fa, hi, hp, h4, rq, vc, nc, st);
    run_instr(32'hFE00_0CE3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (fa !== 32'h10 || imem_addr !== 32'h14) begin
      failures++; $display("FAIL branch_not_taken from=%h to=%h required 00000010 -> 00000014", fa, imem_addr);
    end
    // taken flag without branch must not redirect
    run_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (imem_addr !== 32'h18) begin
      failures++; $display("FAIL taken_without_branch addr=%h required 00000018", imem_addr);
    end
    run_instr(32'h0080_006F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, '0, fa, hi, hp, h4, rq, vc, nc, st);
  endtask

  task automatic test_jalr();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    run_instr(32'h0040_80E7, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 32'h101, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (hp !== 32'h20 || h4 !== 32'h24) begin
      failures++; $display("FAIL jalr_link pc=%h pc_plus4=%h required 00000020/00000024", hp, h4);
    end
    checks++;
    if (imem_addr !== 32'h104 || misaligned !== 1'b0) begin
      failures++; $display("FAIL jalr_target addr=%h mis=%b required 00000104/0", imem_addr, misaligned);
    end
    run_instr(32'h0000_80E7, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h200, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (imem_addr !== 32'h200) begin
      failures++; $display("FAIL jalr_priority addr=%h required 00000200", imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    run_instr(32'h0000_006F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FDFC, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL jump_wrap addr=%h required fffffffc", imem_addr);
    end
    run_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (h4 !== 32'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL seq_wrap pc_plus4=%h addr=%h required 00000000/00000000", h4, imem_addr);
    end
  endtask

  task automatic test_dropped();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    step();
    imem_rvalid = 1'b0;
    exec_done = 1'b1; jump = 1'b1; imm = 32'h40;
    step();
    clear_inputs();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr === 32'hBAD0_0001 || pc !== 32'h0) begin
      failures++; $display("FAIL drop_in_fetch valid=%b req=%b instr=%h pc=%h required 0/0/not bad00001/00000000",
                           instr_valid, imem_req, instr, pc);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_1111) begin
      failures++; $display("FAIL wait_capture valid=%b instr=%h required 1/00001111", instr_valid, instr);
    end
    exec_done = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL drop_resume req=%b addr=%h required 1/00000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    int reqs_seen;
    run_instr(32'hFFDF_F06F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, '0, fa, hi, hp, h4, rq, vc, nc, st);
    run_instr(32'h0060_006F, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (misaligned !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin
      failures++; $display("FAIL trap_entry mis=%b valid=%b req=%b pc=%h required 1/0/0/00000000",
                           misaligned, instr_valid, imem_req, pc);
    end
    reqs_seen = 0;
    for (int i = 0; i < 6; i++) begin
      imem_rvalid = i[0]; exec_done = ~i[0]; jump = 1'b1; imm = 32'd8;
      step();
      reqs_seen += int'(imem_req);
    end
    clear_inputs();
    checks++;
    if (reqs_seen !== 0 || misaligned !== 1'b1 || pc !== 32'h0) begin
      failures++; $display("FAIL trap_sticky reqs=%0d mis=%b pc=%h required 0/1/00000000", reqs_seen, misaligned, pc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    reset = 1'b1;
    #1;
    checks++;
    if (misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_clears_trap mis=%b required 0", misaligned);
    end
    step();
    reset = 1'b0;
    step();
    run_instr(32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, fa, hi, hp, h4, rq, vc, nc, st);
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || instr !== 32'h13 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset_in_wait pc=%h instr=%h req=%b valid=%b required 00000000/00000013/0/0",
                           pc, instr, imem_req, instr_valid);
    end
    step();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h13) begin
      failures++; $display("FAIL stale_rvalid_boot req=%b addr=%h instr=%h required 1/00000000/00000013",
                           imem_req, imem_addr, instr);
    end
    run_instr(32'h0000_2222, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (fa !== 32'h0 || hi !== 32'h0000_2222) begin
      failures++; $display("FAIL refetch_after_reset addr=%h instr=%h required 00000000/00002222", fa, hi);
    end
  endtask

  task automatic test_stall();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    run_instr(32'h0000_3333, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (rq !== 1 || st !== 1'b1 || vc !== 4 || nc !== 11) begin
      failures++; $display("FAIL stall reqs=%0d stable=%0d valid=%0d cycles=%0d required 1/1/4/11", rq, st, vc, nc);
    end
    checks++;
    if (fa !== 32'h4 || hi !== 32'h0000_3333 || imem_addr !== 32'h8) begin
      failures++; $display("FAIL stall_addr fetch=%h instr=%h next=%h required 00000004/00003333/00000008", fa, hi, imem_addr);
    end
  endtask

  task automatic test_jalr_bit1();
    logic [31:0] fa, hi, hp, h4; int rq, vc, nc; bit st;
    run_instr(32'h0000_80E7, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h102, fa, hi, hp, h4, rq, vc, nc, st);
    checks++;
    if (misaligned !== 1'b1 || pc !== 32'h8 || imem_req !== 1'b0) begin
      failures++; $display("FAIL jalr_bit1_trap mis=%b pc=%h req=%b required 1/00000008/0", misaligned, pc, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_wrap();
    test_dropped();
    test_misalign();
    test_reset_mid();
    test_stall();
    test_jalr_bit1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
